lcd_hex_pages: RTL

- Parametrised successor to the two-row, 64-bit debug LCD driver on the ML403 top level.
- Drives an HD44780-compatible 2x16 character LCD over the 4-bit bus.
- Shows NPAGES pages of debug words. Each page is two rows of 16 hex digits, with a per-digit blank mask.
- Pages advance on an external pulse or on an optional auto-rotate timer. The block sits beside the CPU/mem_map debug taps and replaces the fixed single-page display.

---
 rtl/lcd_hex_pages.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/lcd_hex_pages.sv
// Paged hex debug viewer for an HD44780 2x16 LCD (4-bit bus); NPAGES pages of two 64-bit rows.
// Latency: one frame per snapshot, outputs registered; no backpressure, page inputs sampled once per frame.
module lcd_hex_pages #(
  parameter int NPAGES      = 4,
  parameter int CLK_MHZ     = 100,
  parameter int AUTO        = 1,
  parameter int PAGE_CYCLES = 100000000,
  localparam int PW = (NPAGES > 1) ? $clog2(NPAGES) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NPAGES*128-1:0] rows_i,
  input  logic [NPAGES*32-1:0]  masks_i,
  input  logic                  page_next_i,
  output logic [PW-1:0]         page_o,
  output logic                  init_done_o,
  output logic                  frame_o,
  output logic                  lcd_rs_,
  output logic                  lcd_rw_,
  output logic                  lcd_e_,
  output logic [3:0]            lcd_dat_
);

  function automatic logic [31:0] us_cyc(input int us);
    int c;
    c = us * CLK_MHZ;
    if (c < 1) c = 1;
    return 32'(c);
  endfunction

  localparam logic [31:0]   T_1US     = us_cyc(1);
  localparam logic [31:0]   T_40      = us_cyc(40);
  localparam logic [31:0]   T_100     = us_cyc(100);
  localparam logic [31:0]   T_2000    = us_cyc(2000);
  localparam logic [31:0]   T_4100    = us_cyc(4100);
  localparam logic [31:0]   T_PWR     = us_cyc(15000);
  localparam logic [31:0]   TMR_LAST  = 32'(PAGE_CYCLES - 1);
  localparam logic [PW-1:0] PAGE_LAST = PW'(NPAGES - 1);
  localparam logic [5:0]    LAST_ITEM = 6'd33;

  typedef enum logic [2:0] {PWR_WAIT, NIB_SETUP, NIB_HIGH, NIB_HOLD, CMD_WAIT, FRAME_END} state_t;

  function automatic logic [7:0] hex_char(input logic [63:0] w, input logic [15:0] m,
                                          input logic [3:0] k);
    logic [3:0] n;
    n = w[{~k, 2'b00} +: 4];
    if (!m[~k]) return 8'h20;
    if (n < 4'd10) return {4'h3, n};
    return 8'h37 + {4'h0, n};
  endfunction

  // Items 0..7 are the init nibbles/bytes; after init, 0..33 walk one frame: {rs, byte}.
  function automatic logic [8:0] cmd_byte(input logic done, input logic [5:0] item,
                                          input logic [63:0] r1, input logic [15:0] m1,
                                          input logic [63:0] r2, input logic [15:0] m2);
    if (!done) begin
      case (item)
        6'd0, 6'd1, 6'd2: return 9'h003;
        6'd3:             return 9'h002;
        6'd4:             return 9'h028;
        6'd5:             return 9'h00C;
        6'd6:             return 9'h006;
        default:          return 9'h001;
      endcase
    end
    if (item == 6'd0)  return 9'h080;
    if (item == 6'd17) return 9'h0C0;
    if (item < 6'd17)  return {1'b1, hex_char(r1, m1, 4'(item - 6'd1))};
    return {1'b1, hex_char(r2, m2, 4'(item - 6'd18))};
  endfunction

  function automatic logic [31:0] wait_of(input logic done, input logic [5:0] item);
    if (done) return T_40;
    case (item)
      6'd0:    return T_4100;
      6'd1:    return T_100;
      6'd7:    return T_2000;
      default: return T_40;
    endcase
  endfunction

  state_t         state_q, state_d;
  logic [31:0]    cnt_q, cnt_d, tmr_q, tmr_d;
  logic [5:0]     item_q, item_d;
  logic           lo_q, lo_d, init_done_q, init_done_d;
  logic [PW-1:0]  page_q, page_d;
  logic [63:0]    row1_q, row1_d, row2_q, row2_d;
  logic [15:0]    mask1_q, mask1_d, mask2_q, mask2_d;
  logic           e_q, e_d, rs_q, rs_d, frame_q, frame_d;
  logic [3:0]     dat_q, dat_d;
  logic [127:0]   sel_row;
  logic [31:0]    sel_mask;
  logic           snap, adv, nib_only_q, in_nib, rs_n;
  logic [7:0]     byte_n;
  logic [3:0]     nib_n;

  always_comb begin
    sel_row  = '0;
    sel_mask = '0;
    for (int p = 0; p < NPAGES; p++) begin
      if (page_q == PW'(p)) begin
        sel_row  = rows_i[p*128 +: 128];
        sel_mask = masks_i[p*32 +: 32];
      end
    end
  end

  always_comb begin
    adv    = page_next_i;
    tmr_d  = tmr_q;
    page_d = page_q;
    if (AUTO != 0) begin
      if (tmr_q == TMR_LAST) adv = 1'b1;
      tmr_d = adv ? '0 : tmr_q + 32'd1;
    end
    if (adv) page_d = (page_q == PAGE_LAST) ? '0 : page_q + PW'(1);
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 32'd1;
    item_d      = item_q;
    lo_d        = lo_q;
    init_done_d = init_done_q;
    snap        = 1'b0;
    nib_only_q  = !init_done_q && (item_q < 6'd4);
    case (state_q)
      PWR_WAIT: if (cnt_q == T_PWR - 32'd1) begin
        state_d = NIB_SETUP;
        cnt_d   = '0;
      end
      NIB_SETUP: if (cnt_q == T_1US - 32'd1) begin
        state_d = NIB_HIGH;
        cnt_d   = '0;
      end
      NIB_HIGH: if (cnt_q == T_1US - 32'd1) begin
        state_d = NIB_HOLD;
        cnt_d   = '0;
      end
      NIB_HOLD: if (cnt_q == T_1US - 32'd1) begin
        cnt_d = '0;
        if (!nib_only_q && !lo_q) begin
          lo_d    = 1'b1;
          state_d = NIB_SETUP;
        end else begin
          lo_d    = 1'b0;
          state_d = CMD_WAIT;
        end
      end
      CMD_WAIT: if (cnt_q == wait_of(init_done_q, item_q) - 32'd1) begin
        cnt_d   = '0;
        state_d = NIB_SETUP;
        if (!init_done_q && item_q == 6'd7) begin
          init_done_d = 1'b1;
          item_d      = '0;
          snap        = 1'b1;
        end else if (init_done_q && item_q == LAST_ITEM) begin
          state_d = FRAME_END;
        end else begin
          item_d = item_q + 6'd1;
        end
      end
      FRAME_END: begin
        cnt_d   = '0;
        item_d  = '0;
        snap    = 1'b1;
        state_d = NIB_SETUP;
      end
      default: begin
        state_d = PWR_WAIT;
        cnt_d   = '0;
      end
    endcase

    // Bus values are decoded from the next item so RS/data are already valid in the setup phase.
    {rs_n, byte_n} = cmd_byte(init_done_d, item_d, row1_q, mask1_q, row2_q, mask2_q);
    nib_n   = (lo_d || (!init_done_d && item_d < 6'd4)) ? byte_n[3:0] : byte_n[7:4];
    in_nib  = state_d inside {NIB_SETUP, NIB_HIGH, NIB_HOLD};
    e_d     = (state_d == NIB_HIGH);
    rs_d    = in_nib && rs_n;
    dat_d   = in_nib ? nib_n : 4'h0;
    frame_d = (state_d == FRAME_END);
    row1_d  = snap ? sel_row[127:64] : row1_q;
    row2_d  = snap ? sel_row[63:0]   : row2_q;
    mask1_d = snap ? sel_mask[31:16] : mask1_q;
    mask2_d = snap ? sel_mask[15:0]  : mask2_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q     <= PWR_WAIT;
      cnt_q       <= '0;
      tmr_q       <= '0;
      item_q      <= '0;
      lo_q        <= 1'b0;
      init_done_q <= 1'b0;
      page_q      <= '0;
      row1_q      <= '0;
      row2_q      <= '0;
      mask1_q     <= '0;
      mask2_q     <= '0;
      e_q         <= 1'b0;
      rs_q        <= 1'b0;
      dat_q       <= '0;
      frame_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tmr_q       <= tmr_d;
      item_q      <= item_d;
      lo_q        <= lo_d;
      init_done_q <= init_done_d;
      page_q      <= page_d;
      row1_q      <= row1_d;
      row2_q      <= row2_d;
      mask1_q     <= mask1_d;
      mask2_q     <= mask2_d;
      e_q         <= e_d;
      rs_q        <= rs_d;
      dat_q       <= dat_d;
      frame_q     <= frame_d;
    end
  end

  assign page_o      = page_q;
  assign init_done_o = init_done_q;
  assign frame_o     = frame_q;
  assign lcd_rs_     = rs_q;
  assign lcd_rw_     = 1'b0;
  assign lcd_e_      = e_q;
  assign lcd_dat_    = dat_q;

endmodule
